// File: rtl/pd_power_sequencer.sv
// Per-domain power sequencer: walks switch, reset, clock, isolation and retention controls
// through a fixed timed order, with power-switch handshake, timeout and sticky error.
module pd_power_sequencer #(
    parameter int NUM_PD      = 10,
    parameter int CNT_W       = 8,
    parameter int SETTLE_CYC  = 16,
    parameter int STEP_CYC    = 2,
    parameter int TIMEOUT_CYC = 200
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NUM_PD-1:0] pd_req,
    input  logic [NUM_PD-1:0] pd_ret_req,
    input  logic [NUM_PD-1:0] pwr_ack,
    input  logic [NUM_PD-1:0] err_clr,
    output logic [NUM_PD-1:0] pwr_sw_en,
    output logic [NUM_PD-1:0] pd_iso_n,
    output logic [NUM_PD-1:0] pd_ret_n,
    output logic [NUM_PD-1:0] pd_rst_n,
    output logic [NUM_PD-1:0] pd_clk_en,
    output logic [NUM_PD-1:0] pd_on,
    output logic              pd_busy,
    output logic [NUM_PD-1:0] pd_err
);

    typedef enum logic [3:0] {
        ST_OFF      = 4'd0,
        ST_PWR_UP   = 4'd1,
        ST_SETTLE   = 4'd2,
        ST_RESTORE  = 4'd3,
        ST_RST_REL  = 4'd4,
        ST_CLK_EN   = 4'd5,
        ST_ISO_REL  = 4'd6,
        ST_ON       = 4'd7,
        ST_CLK_GATE = 4'd8,
        ST_ISO_ON   = 4'd9,
        ST_RET_SAVE = 4'd10,
        ST_RST_ON   = 4'd11,
        ST_PWR_DN   = 4'd12,
        ST_ERR      = 4'd13
    } state_t;

    // Counter values at which a state is left (counter is zero in the first cycle of a state)
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] STEP_LAST    = CNT_W'(STEP_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};

    if (TIMEOUT_CYC >= (1 << CNT_W)) begin : g_cfg_check
        $error("pd_power_sequencer: TIMEOUT_CYC must be less than 2**CNT_W");
    end

    logic [NUM_PD-1:0] busy_vec_s;

    assign pd_busy = |busy_vec_s;

    for (genvar i = 0; i < NUM_PD; i++) begin : g_pd
        state_t           state_r;
        logic [CNT_W-1:0] cnt_r;
        logic             ret_lat_r;
        logic             sw_en_r;
        logic             iso_n_r;
        logic             ret_n_r;
        logic             rst_n_r;
        logic             clk_en_r;
        logic             on_r;
        logic             err_r;
        logic             busy_r;

        // Domain FSM: state, saturating timing counter and all registered domain controls
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                state_r   <= ST_OFF;
                cnt_r     <= CNT_ZERO;
                ret_lat_r <= 1'b0;
                sw_en_r   <= 1'b0;
                iso_n_r   <= 1'b0;
                ret_n_r   <= 1'b1;
                rst_n_r   <= 1'b0;
                clk_en_r  <= 1'b0;
                on_r      <= 1'b0;
                err_r     <= 1'b0;
                busy_r    <= 1'b0;
            end else begin
                if (cnt_r != CNT_MAX) begin
                    cnt_r <= cnt_r + 1'b1;
                end else begin
                    cnt_r <= cnt_r;
                end
                case (state_r)
                    ST_OFF: begin
                        if (pd_req[i]) begin
                            state_r <= ST_PWR_UP; cnt_r <= CNT_ZERO;
                            sw_en_r <= 1'b1; busy_r <= 1'b1;
                        end
                    end
                    ST_PWR_UP: begin
                        if (pwr_ack[i]) begin
                            state_r <= ST_SETTLE; cnt_r <= CNT_ZERO;
                        end else if (cnt_r == TIMEOUT_LAST) begin
                            state_r <= ST_ERR; cnt_r <= CNT_ZERO;
                            sw_en_r <= 1'b0; iso_n_r <= 1'b0; rst_n_r <= 1'b0;
                            clk_en_r <= 1'b0; on_r <= 1'b0; err_r <= 1'b1; busy_r <= 1'b0;
                        end
                    end
                    ST_SETTLE: begin
                        if (cnt_r == SETTLE_LAST) begin
                            cnt_r <= CNT_ZERO;
                            if (!ret_n_r) begin
                                state_r <= ST_RESTORE; ret_n_r <= 1'b1;
                            end else begin
                                state_r <= ST_RST_REL; rst_n_r <= 1'b1;
                            end
                        end
                    end
                    ST_RESTORE: begin
                        if (cnt_r == STEP_LAST) begin
                            state_r <= ST_RST_REL; cnt_r <= CNT_ZERO; rst_n_r <= 1'b1;
                        end
                    end
                    ST_RST_REL: begin
                        if (cnt_r == STEP_LAST) begin
                            state_r <= ST_CLK_EN; cnt_r <= CNT_ZERO; clk_en_r <= 1'b1;
                        end
                    end
                    ST_CLK_EN: begin
                        if (cnt_r == STEP_LAST) begin
                            state_r <= ST_ISO_REL; cnt_r <= CNT_ZERO; iso_n_r <= 1'b1;
                        end
                    end
                    ST_ISO_REL: begin
                        if (cnt_r == STEP_LAST) begin
                            state_r <= ST_ON; cnt_r <= CNT_ZERO; on_r <= 1'b1; busy_r <= 1'b0;
                        end
                    end
                    ST_ON: begin
                        if (!pd_req[i]) begin
                            state_r <= ST_CLK_GATE; cnt_r <= CNT_ZERO; on_r <= 1'b0;
                            clk_en_r <= 1'b0; ret_lat_r <= pd_ret_req[i]; busy_r <= 1'b1;
                        end
                    end
                    ST_CLK_GATE: begin
                        if (cnt_r == STEP_LAST) begin
                            state_r <= ST_ISO_ON; cnt_r <= CNT_ZERO; iso_n_r <= 1'b0;
                        end
                    end
                    ST_ISO_ON: begin
                        if (cnt_r == STEP_LAST) begin
                            cnt_r <= CNT_ZERO;
                            if (ret_lat_r) begin
                                state_r <= ST_RET_SAVE; ret_n_r <= 1'b0;
                            end else begin
                                state_r <= ST_RST_ON; rst_n_r <= 1'b0;
                            end
                        end
                    end
                    ST_RET_SAVE: begin
                        if (cnt_r == STEP_LAST) begin
                            state_r <= ST_RST_ON; cnt_r <= CNT_ZERO; rst_n_r <= 1'b0;
                        end
                    end
                    ST_RST_ON: begin
                        if (cnt_r == STEP_LAST) begin
                            state_r <= ST_PWR_DN; cnt_r <= CNT_ZERO; sw_en_r <= 1'b0;
                        end
                    end
                    ST_PWR_DN: begin
                        if (!pwr_ack[i]) begin
                            state_r <= ST_OFF; cnt_r <= CNT_ZERO; busy_r <= 1'b0;
                        end else if (cnt_r == TIMEOUT_LAST) begin
                            state_r <= ST_ERR; cnt_r <= CNT_ZERO;
                            sw_en_r <= 1'b0; iso_n_r <= 1'b0; rst_n_r <= 1'b0;
                            clk_en_r <= 1'b0; on_r <= 1'b0; err_r <= 1'b1; busy_r <= 1'b0;
                        end
                    end
                    ST_ERR: begin
                        if (err_clr[i]) begin
                            state_r <= ST_OFF; cnt_r <= CNT_ZERO; err_r <= 1'b0;
                        end
                    end
                    // Unreachable encodings fall into the safe error state
                    default: begin
                        state_r <= ST_ERR; cnt_r <= CNT_ZERO;
                        sw_en_r <= 1'b0; iso_n_r <= 1'b0; rst_n_r <= 1'b0;
                        clk_en_r <= 1'b0; on_r <= 1'b0; err_r <= 1'b1; busy_r <= 1'b0;
                    end
                endcase
            end
        end

        assign pwr_sw_en[i]  = sw_en_r;
        assign pd_iso_n[i]   = iso_n_r;
        assign pd_ret_n[i]   = ret_n_r;
        assign pd_rst_n[i]   = rst_n_r;
        assign pd_clk_en[i]  = clk_en_r;
        assign pd_on[i]      = on_r;
        assign pd_err[i]     = err_r;
        assign busy_vec_s[i] = busy_r;
    end

endmodule

// File: tb/tb_pd_power_sequencer.sv
// Directed bench for pd_power_sequencer: cycle-exact checks of up/down sequencing,
// retention, timeout error, request toggling, all-domain operation and mid-sequence reset.
module tb_pd_power_sequencer;

    localparam int N = 10;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [N-1:0] pd_req = '0;
    logic [N-1:0] pd_ret_req = '0;
    logic [N-1:0] pwr_ack = '0;
    logic [N-1:0] err_clr = '0;
    logic [N-1:0] pwr_sw_en, pd_iso_n, pd_ret_n, pd_rst_n, pd_clk_en, pd_on, pd_err;
    logic         pd_busy;

    int vectors = 0;
    int fails   = 0;
    int cyc     = 0;

    pd_power_sequencer #(
        .NUM_PD(N), .CNT_W(8), .SETTLE_CYC(16), .STEP_CYC(2), .TIMEOUT_CYC(200)
    ) dut (
        .clk(clk), .rstn(rstn), .pd_req(pd_req), .pd_ret_req(pd_ret_req),
        .pwr_ack(pwr_ack), .err_clr(err_clr), .pwr_sw_en(pwr_sw_en),
        .pd_iso_n(pd_iso_n), .pd_ret_n(pd_ret_n), .pd_rst_n(pd_rst_n),
        .pd_clk_en(pd_clk_en), .pd_on(pd_on), .pd_busy(pd_busy), .pd_err(pd_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        pd_req = '0; pd_ret_req = '0; pwr_ack = '0; err_clr = '0;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (pwr_sw_en !== 10'h000) begin fails++; $display("FAIL rst_sw_en: got %h want %h", pwr_sw_en, 10'h000); end
        vectors++; if (pd_iso_n !== 10'h000) begin fails++; $display("FAIL rst_iso_n: got %h want %h", pd_iso_n, 10'h000); end
        vectors++; if (pd_ret_n !== 10'h3ff) begin fails++; $display("FAIL rst_ret_n: got %h want %h", pd_ret_n, 10'h3ff); end
        vectors++; if (pd_rst_n !== 10'h000) begin fails++; $display("FAIL rst_rst_n: got %h want %h", pd_rst_n, 10'h000); end
        vectors++; if (pd_clk_en !== 10'h000) begin fails++; $display("FAIL rst_clk_en: got %h want %h", pd_clk_en, 10'h000); end
        vectors++; if (pd_on !== 10'h000) begin fails++; $display("FAIL rst_on: got %h want %h", pd_on, 10'h000); end
        vectors++; if (pd_err !== 10'h000) begin fails++; $display("FAIL rst_err: got %h want %h", pd_err, 10'h000); end
        vectors++; if (pd_busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", pd_busy); end
    endtask

    // Domain 0 up: sw_en @1, ack after 6, settle entered @7, rst @23, clk @25, iso @27, on @29
    task automatic test_power_up();
        pd_req[0] = 1'b1;
        step();
        vectors++; if (pwr_sw_en !== 10'h001) begin fails++; $display("FAIL up_sw_en: got %h want %h", pwr_sw_en, 10'h001); end
        vectors++; if (pd_busy !== 1'b1) begin fails++; $display("FAIL up_busy: got %b want 1", pd_busy); end
        run_to(6);
        pwr_ack[0] = 1'b1;
        run_to(22);
        vectors++; if (pd_rst_n[0] !== 1'b0) begin fails++; $display("FAIL up_rst_early: got %b want 0", pd_rst_n[0]); end
        step();
        vectors++; if (pd_rst_n[0] !== 1'b1) begin fails++; $display("FAIL up_rst_rel: got %b want 1", pd_rst_n[0]); end
        vectors++; if (pd_clk_en[0] !== 1'b0) begin fails++; $display("FAIL up_clk_early: got %b want 0", pd_clk_en[0]); end
        run_to(25);
        vectors++; if (pd_clk_en[0] !== 1'b1) begin fails++; $display("FAIL up_clk_en: got %b want 1", pd_clk_en[0]); end
        vectors++; if (pd_iso_n[0] !== 1'b0) begin fails++; $display("FAIL up_iso_early: got %b want 0", pd_iso_n[0]); end
        run_to(27);
        vectors++; if (pd_iso_n[0] !== 1'b1) begin fails++; $display("FAIL up_iso_rel: got %b want 1", pd_iso_n[0]); end
        run_to(28);
        vectors++; if (pd_on[0] !== 1'b0) begin fails++; $display("FAIL up_on_early: got %b want 0", pd_on[0]); end
        step();
        vectors++; if (pd_on !== 10'h001) begin fails++; $display("FAIL up_on: got %h want %h", pd_on, 10'h001); end
        vectors++; if (pd_busy !== 1'b0) begin fails++; $display("FAIL up_busy_done: got %b want 0", pd_busy); end
        vectors++; if (pwr_sw_en !== 10'h001) begin fails++; $display("FAIL up_others: got %h want %h", pwr_sw_en, 10'h001); end
        vectors++; if (pd_rst_n !== 10'h001) begin fails++; $display("FAIL up_rst_vec: got %h want %h", pd_rst_n, 10'h001); end
        err_clr[0] = 1'b1;
        step();
        err_clr[0] = 1'b0;
        vectors++; if (pd_on[0] !== 1'b1 || pd_err[0] !== 1'b0) begin fails++; $display("FAIL up_errclr_ignored: got on=%b err=%b want on=1 err=0", pd_on[0], pd_err[0]); end
    endtask

    // Down with retention from cyc 30: clk_gate @31, iso @33, ret @35, rst @37, sw off @39, OFF @40
    task automatic test_power_down_ret();
        pd_ret_req[0] = 1'b1;
        pd_req[0] = 1'b0;
        step();
        vectors++; if (pd_on[0] !== 1'b0 || pd_clk_en[0] !== 1'b0) begin fails++; $display("FAIL dn_clk_gate: got on=%b clk=%b want 0/0", pd_on[0], pd_clk_en[0]); end
        vectors++; if (pd_iso_n[0] !== 1'b1) begin fails++; $display("FAIL dn_iso_early: got %b want 1", pd_iso_n[0]); end
        run_to(33);
        vectors++; if (pd_iso_n[0] !== 1'b0) begin fails++; $display("FAIL dn_iso_on: got %b want 0", pd_iso_n[0]); end
        run_to(34);
        vectors++; if (pd_ret_n[0] !== 1'b1) begin fails++; $display("FAIL dn_ret_early: got %b want 1", pd_ret_n[0]); end
        step();
        vectors++; if (pd_ret_n[0] !== 1'b0) begin fails++; $display("FAIL dn_ret_save: got %b want 0", pd_ret_n[0]); end
        vectors++; if (pd_rst_n[0] !== 1'b1) begin fails++; $display("FAIL dn_rst_early: got %b want 1", pd_rst_n[0]); end
        run_to(37);
        vectors++; if (pd_rst_n[0] !== 1'b0) begin fails++; $display("FAIL dn_rst_on: got %b want 0", pd_rst_n[0]); end
        vectors++; if (pwr_sw_en[0] !== 1'b1) begin fails++; $display("FAIL dn_sw_early: got %b want 1", pwr_sw_en[0]); end
        run_to(39);
        vectors++; if (pwr_sw_en[0] !== 1'b0) begin fails++; $display("FAIL dn_sw_off: got %b want 0", pwr_sw_en[0]); end
        vectors++; if (pd_busy !== 1'b1) begin fails++; $display("FAIL dn_busy: got %b want 1", pd_busy); end
        pwr_ack[0] = 1'b0;
        pd_ret_req[0] = 1'b0;
        step();
        vectors++; if (pd_busy !== 1'b0) begin fails++; $display("FAIL dn_off_busy: got %b want 0", pd_busy); end
        vectors++; if (pd_ret_n !== 10'h3fe) begin fails++; $display("FAIL dn_off_ret: got %h want %h", pd_ret_n, 10'h3fe); end
    endtask

    // Re-request from OFF @40: sw @41, settle @42, restore @58, rst_rel @60, on @66
    task automatic test_restore();
        pd_req[0] = 1'b1;
        step();
        vectors++; if (pwr_sw_en[0] !== 1'b1 || pd_ret_n[0] !== 1'b0) begin fails++; $display("FAIL rs_pwr_up: got sw=%b ret=%b want 1/0", pwr_sw_en[0], pd_ret_n[0]); end
        pwr_ack[0] = 1'b1;
        run_to(57);
        vectors++; if (pd_ret_n[0] !== 1'b0) begin fails++; $display("FAIL rs_ret_early: got %b want 0", pd_ret_n[0]); end
        step();
        vectors++; if (pd_ret_n[0] !== 1'b1 || pd_rst_n[0] !== 1'b0) begin fails++; $display("FAIL rs_restore: got ret=%b rst=%b want 1/0", pd_ret_n[0], pd_rst_n[0]); end
        run_to(59);
        vectors++; if (pd_rst_n[0] !== 1'b0) begin fails++; $display("FAIL rs_rst_hold: got %b want 0", pd_rst_n[0]); end
        step();
        vectors++; if (pd_rst_n[0] !== 1'b1) begin fails++; $display("FAIL rs_rst_rel: got %b want 1", pd_rst_n[0]); end
        run_to(65);
        vectors++; if (pd_on[0] !== 1'b0) begin fails++; $display("FAIL rs_on_early: got %b want 0", pd_on[0]); end
        step();
        vectors++; if (pd_on[0] !== 1'b1) begin fails++; $display("FAIL rs_on: got %b want 1", pd_on[0]); end
    endtask

    // Domain 3 with no ack: 200 cycles in PWR_UP (sw @1), error @201
    task automatic test_timeout();
        do_reset();
        pd_req[3] = 1'b1;
        step();
        vectors++; if (pwr_sw_en !== 10'h008) begin fails++; $display("FAIL to_sw_en: got %h want %h", pwr_sw_en, 10'h008); end
        run_to(200);
        vectors++; if (pd_err[3] !== 1'b0 || pwr_sw_en[3] !== 1'b1) begin fails++; $display("FAIL to_early: got err=%b sw=%b want 0/1", pd_err[3], pwr_sw_en[3]); end
        step();
        vectors++; if (pd_err !== 10'h008) begin fails++; $display("FAIL to_err: got %h want %h", pd_err, 10'h008); end
        vectors++; if (pwr_sw_en !== 10'h000 || pd_iso_n !== 10'h000) begin fails++; $display("FAIL to_safe_sw_iso: got sw=%h iso=%h want 000/000", pwr_sw_en, pd_iso_n); end
        vectors++; if (pd_rst_n !== 10'h000 || pd_clk_en !== 10'h000) begin fails++; $display("FAIL to_safe_rst_clk: got rst=%h clk=%h want 000/000", pd_rst_n, pd_clk_en); end
        vectors++; if (pd_busy !== 1'b0) begin fails++; $display("FAIL to_busy: got %b want 0", pd_busy); end
        run_to(205);
        vectors++; if (pd_err[3] !== 1'b1) begin fails++; $display("FAIL to_sticky: got %b want 1", pd_err[3]); end
        err_clr[3] = 1'b1;
        step();
        err_clr[3] = 1'b0;
        vectors++; if (pd_err[3] !== 1'b0) begin fails++; $display("FAIL to_clr: got %b want 0", pd_err[3]); end
        step();
        vectors++; if (pwr_sw_en[3] !== 1'b1) begin fails++; $display("FAIL to_repower: got %b want 1", pwr_sw_en[3]); end
        pwr_ack[3] = 1'b1;
        run_to(229);
        vectors++; if (pd_on[3] !== 1'b0) begin fails++; $display("FAIL to_on_early: got %b want 0", pd_on[3]); end
        step();
        vectors++; if (pd_on !== 10'h008) begin fails++; $display("FAIL to_on: got %h want %h", pd_on, 10'h008); end
    endtask

    // Request dropped during SETTLE: reaches ON @24, then starts down @25
    task automatic test_req_toggle();
        do_reset();
        pd_req[1] = 1'b1;
        step();
        pwr_ack[1] = 1'b1;
        run_to(5);
        pd_req[1] = 1'b0;
        run_to(23);
        vectors++; if (pd_on[1] !== 1'b0 || pd_busy !== 1'b1) begin fails++; $display("FAIL tg_pre_on: got on=%b busy=%b want 0/1", pd_on[1], pd_busy); end
        step();
        vectors++; if (pd_on[1] !== 1'b1 || pd_busy !== 1'b0) begin fails++; $display("FAIL tg_on: got on=%b busy=%b want 1/0", pd_on[1], pd_busy); end
        step();
        vectors++; if (pd_on[1] !== 1'b0 || pd_clk_en[1] !== 1'b0 || pd_busy !== 1'b1) begin fails++; $display("FAIL tg_down: got on=%b clk=%b busy=%b want 0/0/1", pd_on[1], pd_clk_en[1], pd_busy); end
    endtask

    // All domains at once, ack delay 2+3*i after sw_en -> ON at cycle 26+3*i, last at 53
    task automatic test_all_domains();
        logic [N-1:0] exp_on;
        do_reset();
        pd_req = '1;
        for (int c = 1; c <= 60; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (cyc >= 3 + 3 * i) pwr_ack[i] = 1'b1;
                exp_on[i] = (cyc >= 26 + 3 * i);
            end
            vectors++; if (pd_on !== exp_on) begin fails++; $display("FAIL all_on cyc %0d: got %h want %h", cyc, pd_on, exp_on); end
            vectors++; if (pd_busy !== (cyc < 53)) begin fails++; $display("FAIL all_busy cyc %0d: got %b want %b", cyc, pd_busy, (cyc < 53)); end
        end
    endtask

    // Domain 2 down with retention; reset hits during RET_SAVE (entered @29)
    task automatic test_reset_mid_ret();
        do_reset();
        pd_req[2] = 1'b1;
        pd_ret_req[2] = 1'b1;
        step();
        pwr_ack[2] = 1'b1;
        run_to(24);
        vectors++; if (pd_on[2] !== 1'b1) begin fails++; $display("FAIL mr_on: got %b want 1", pd_on[2]); end
        pd_req[2] = 1'b0;
        run_to(30);
        vectors++; if (pd_ret_n !== 10'h3fb) begin fails++; $display("FAIL mr_ret_save: got %h want %h", pd_ret_n, 10'h3fb); end
        #2 rstn = 1'b0;
        #1;
        vectors++; if (pwr_sw_en !== 10'h000 || pd_iso_n !== 10'h000) begin fails++; $display("FAIL mr_rst_sw_iso: got sw=%h iso=%h want 000/000", pwr_sw_en, pd_iso_n); end
        vectors++; if (pd_ret_n !== 10'h3ff || pd_rst_n !== 10'h000) begin fails++; $display("FAIL mr_rst_ret_rst: got ret=%h rst=%h want 3ff/000", pd_ret_n, pd_rst_n); end
        vectors++; if (pd_clk_en !== 10'h000 || pd_on !== 10'h000) begin fails++; $display("FAIL mr_rst_clk_on: got clk=%h on=%h want 000/000", pd_clk_en, pd_on); end
        vectors++; if (pd_err !== 10'h000 || pd_busy !== 1'b0) begin fails++; $display("FAIL mr_rst_err_busy: got err=%h busy=%b want 000/0", pd_err, pd_busy); end
        pwr_ack = '0;
        pd_ret_req = '0;
        #2 rstn = 1'b1;
        repeat (3) step();
        vectors++; if (pwr_sw_en !== 10'h000 || pd_busy !== 1'b0 || pd_ret_n !== 10'h3ff) begin fails++; $display("FAIL mr_idle: got sw=%h busy=%b ret=%h want 000/0/3ff", pwr_sw_en, pd_busy, pd_ret_n); end
        pd_req[2] = 1'b1;
        step();
        vectors++; if (pwr_sw_en !== 10'h004 || pd_busy !== 1'b1) begin fails++; $display("FAIL mr_from_off: got sw=%h busy=%b want 004/1", pwr_sw_en, pd_busy); end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_power_down_ret();
        test_restore();
        test_timeout();
        test_req_toggle();
        test_all_domains();
        test_reset_mid_ret();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
